mem_arbiter: RTL and testbench

Shares the single-port instruction/data RAM between the PC fetch path and the load/store path of the single-cycle core. Each side issues a held request. The arbiter grants one access at a time, drives the RAM for a fixed number of cycles, and returns read data with a one-cycle ready pulse (`i_ready` / `d_ready`). It sits between `pc`/`control` and the RAM, taking over the sequencing currently folded into the RAM wrapper.

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port RAM between fetch and load/store, one timed access at a time.
// Define MEM_ARB_RR_EN for round-robin between simultaneous requests; otherwise data always wins.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_ren,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic wr_q, wr_d, i_ready_q, i_ready_d, d_ready_q, d_ready_d;
  logic ren_q, ren_d, wen_q, wen_d, busy_q, busy_d;
  logic i_el, d_el, pick_d;
  // a side whose ready is showing has just completed and must not be re-granted at this edge
  assign i_el = i_req & ~i_ready_q;
  assign d_el = (d_ren | d_wen) & ~d_ready_q;
`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
  assign pick_d = d_el & (~i_el | ~last_q);
`else
  assign pick_d = d_el;
`endif
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_ren   = ren_q;
  assign ram_wen   = wen_q;
  assign busy      = busy_q;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    ren_d     = ren_q;
    wen_d     = wen_q;
    busy_d    = busy_q;
`ifdef MEM_ARB_RR_EN
    last_d    = last_q;
`endif
    if (state_q == IDLE) begin
      if (pick_d) begin
        state_d = D_ACC;
        cnt_d   = CW'(LATENCY - 1);
        addr_d  = d_addr;
        wdata_d = d_wdata;
        wr_d    = d_wen;
        ren_d   = ~d_wen;
        wen_d   = d_wen;
        busy_d  = 1'b1;
`ifdef MEM_ARB_RR_EN
        last_d  = 1'b1;
`endif
      end else if (i_el) begin
        state_d = I_ACC;
        cnt_d   = CW'(LATENCY - 1);
        addr_d  = i_addr;
        wr_d    = 1'b0;
        ren_d   = 1'b1;
        wen_d   = 1'b0;
        busy_d  = 1'b1;
`ifdef MEM_ARB_RR_EN
        last_d  = 1'b0;
`endif
      end
    end else if (cnt_q == '0) begin
      state_d = IDLE;
      ren_d   = 1'b0;
      wen_d   = 1'b0;
      busy_d  = 1'b0;
      if (state_q == I_ACC) begin
        i_rdata_d = ram_rdata;
        i_ready_d = 1'b1;
      end else begin
        d_ready_d = 1'b1;
        d_rdata_d = wr_q ? d_rdata_q : ram_rdata;
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      ren_q     <= ren_d;
      wen_q     <= wen_d;
      busy_q    <= busy_d;
`ifdef MEM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int L = 2;
  logic clk = 1'b0, nRST = 1'b0, init_req = 1'b1;
  logic i_req = 1'b0, d_ren = 1'b0, d_wen = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] i_rdata, d_rdata, ram_addr, ram_wdata, ram_rdata;
  logic i_ready, d_ready, ram_ren, ram_wen, busy;
  logic [31:0] ram [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_i = '0, exp_d = '0;
  logic last_side = 1'b0;
  int tests = 0, fails = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(L)) dut (
    .clk(clk), .nRST(nRST), .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_rdata(ram_rdata), .busy(busy));

  function automatic logic [31:0] init_val(int k);
    logic [7:0] kb;
    kb = 8'(k);
    return (k == 4) ? 32'h0010_0093 : {8'hA5, kb, 16'(k * 37)};
  endfunction

  always #5 clk = ~clk;
  always @(posedge clk)
    if (init_req) for (int k = 0; k < 64; k++) ram[k] <= init_val(k);
    else if (ram_wen) ram[ram_addr[7:2]] <= ram_wdata;
  assign ram_rdata = ram_ren ? ram[ram_addr[7:2]] : '0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    i_req = 0; d_ren = 0; d_wen = 0;
    nRST = 0; init_req = 1;
    repeat (3) tick;
    nRST = 1; init_req = 0;
    exp_i = '0; exp_d = '0; last_side = 0;
  endtask

  task automatic test_reset;
    apply_reset;
    tests++;
    if ({i_rdata, d_rdata, ram_addr, ram_wdata, i_ready, d_ready, ram_ren, ram_wen, busy} !== '0) begin
      fails++; $display("FAIL reset_state: outputs not all zero (busy=%b ren=%b wen=%b)", busy, ram_ren, ram_wen);
    end
  endtask

  task automatic test_fetch;
    i_req = 1; i_addr = 32'h10;
    tick;
    tests++;
    if ({ram_ren, ram_wen, busy, ram_addr} !== {3'b101, 32'h10}) begin
      fails++; $display("FAIL fetch_grant: ren/wen/busy=%b%b%b addr=%h want 101 addr 10", ram_ren, ram_wen, busy, ram_addr);
    end
    for (int k = 1; k < L; k++) begin
      tick; tests++;
      if (ram_ren !== 1'b1) begin fails++; $display("FAIL fetch_ren_hold: got %b want 1", ram_ren); end
    end
    tick; tests++;
    if ({ram_ren, i_ready, busy, i_rdata} !== {3'b010, 32'h0010_0093}) begin
      fails++; $display("FAIL fetch_done: ren/rdy/busy=%b%b%b rdata=%h want 010 00100093", ram_ren, i_ready, busy, i_rdata);
    end
    i_req = 0; exp_i = 32'h0010_0093; last_side = 0;
    tick; tests++;
    if (i_ready !== 1'b0) begin fails++; $display("FAIL fetch_pulse: i_ready=%b want 0", i_ready); end
  endtask

  task automatic test_write_read;
    d_wen = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    for (int k = 0; k < L; k++) begin
      tick; tests++;
      if ({ram_wen, ram_ren, ram_addr, ram_wdata} !== {2'b10, 32'h40, 32'hDEAD_BEEF}) begin
        fails++; $display("FAIL write_drive: wen/ren=%b%b addr=%h wdata=%h", ram_wen, ram_ren, ram_addr, ram_wdata);
      end
    end
    tick; tests++;
    if ({ram_wen, d_ready, d_rdata} !== {2'b01, exp_d}) begin
      fails++; $display("FAIL write_done: wen=%b d_ready=%b d_rdata=%h want 0 1 %h", ram_wen, d_ready, d_rdata, exp_d);
    end
    d_wen = 0; d_ren = 1;
    tick; tests++;
    if ({busy, d_ready} !== 2'b00) begin fails++; $display("FAIL read_excluded: busy=%b d_ready=%b want 00", busy, d_ready); end
    tick; tests++;
    if ({ram_ren, ram_addr} !== {1'b1, 32'h40}) begin fails++; $display("FAIL read_grant: ren=%b addr=%h", ram_ren, ram_addr); end
    repeat (L - 1) tick;
    tick; tests++;
    if ({d_ready, d_rdata, i_rdata} !== {1'b1, 32'hDEAD_BEEF, exp_i}) begin
      fails++; $display("FAIL read_back: d_ready=%b d_rdata=%h i_rdata=%h want 1 deadbeef %h", d_ready, d_rdata, i_rdata, exp_i);
    end
    d_ren = 0; exp_d = 32'hDEAD_BEEF; last_side = 1;
    tick;
  endtask

  task automatic test_both_ops;
    logic [31:0] wd;
    int pulses;
    wd = $urandom; pulses = 0;
    d_ren = 1; d_wen = 1; d_addr = 32'h80; d_wdata = wd;
    for (int k = 0; k < L; k++) begin
      tick; tests++;
      if ({ram_wen, ram_ren} !== 2'b10) begin fails++; $display("FAIL both_is_write: wen/ren=%b%b want 10", ram_wen, ram_ren); end
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      if (d_ready) pulses++;
      if (k == 0) begin d_ren = 0; d_wen = 0; end
    end
    tests++;
    if (pulses != 1 || d_rdata !== exp_d) begin
      fails++; $display("FAIL both_done: pulses=%0d d_rdata=%h want 1 %h", pulses, d_rdata, exp_d);
    end
    tests++;
    if (ram[32] !== wd) begin fails++; $display("FAIL both_stored: ram=%h want %h", ram[32], wd); end
    last_side = 1;
  endtask

  task automatic test_priority;
    logic dfirst;
    apply_reset;
    for (int r = 0; r < 3; r++) begin
      if (r == 2) begin
        d_ren = 1; d_addr = 32'h30;
        repeat (L + 1) tick;
        tests++;
        if (d_ready !== 1'b1) begin fails++; $display("FAIL lone_read: d_ready=%b want 1", d_ready); end
        d_ren = 0; exp_d = init_val(12); last_side = 1;
        tick;
      end
`ifdef MEM_ARB_RR_EN
      dfirst = !last_side;
`else
      dfirst = 1;
`endif
      i_req = 1; i_addr = 32'h20; d_ren = 1; d_addr = 32'h30;
      tick; tests++;
      if ({ram_ren, ram_addr} !== {1'b1, dfirst ? 32'h30 : 32'h20}) begin
        fails++; $display("FAIL prio_first r%0d: ren=%b addr=%h want data_first=%b", r, ram_ren, ram_addr, dfirst);
      end
      repeat (L - 1) tick;
      tick; tests++;
      if ({d_ready, i_ready} !== (dfirst ? 2'b10 : 2'b01)) begin
        fails++; $display("FAIL prio_ready1 r%0d: d/i ready=%b%b data_first=%b", r, d_ready, i_ready, dfirst);
      end
      if (dfirst) d_ren = 0; else i_req = 0;
      tick; tests++;
      if ({ram_ren, ram_addr, d_ready, i_ready} !== {1'b1, dfirst ? 32'h20 : 32'h30, 2'b00}) begin
        fails++; $display("FAIL prio_second r%0d: ren=%b addr=%h d/i ready=%b%b", r, ram_ren, ram_addr, d_ready, i_ready);
      end
      repeat (L - 1) tick;
      tick; tests++;
      if ({d_ready, i_ready, d_rdata, i_rdata} !== {dfirst ? 2'b01 : 2'b10, init_val(12), init_val(8)}) begin
        fails++; $display("FAIL prio_ready2 r%0d: d/i ready=%b%b d=%h i=%h", r, d_ready, i_ready, d_rdata, i_rdata);
      end
      i_req = 0; d_ren = 0;
      exp_d = init_val(12); exp_i = init_val(8); last_side = !dfirst;
      tick;
    end
  endtask

  task automatic test_reset_mid_write;
    d_wen = 1; d_addr = 32'hC0; d_wdata = 32'h1234_5678;
    tick; tests++;
    if (ram_wen !== 1'b1) begin fails++; $display("FAIL midrst_start: wen=%b want 1", ram_wen); end
    #2 nRST = 0;
    #1 tests++;
    if ({ram_wen, busy, i_ready, d_ready} !== 4'b0000) begin
      fails++; $display("FAIL midrst_async: wen/busy/ir/dr=%b%b%b%b want 0000", ram_wen, busy, i_ready, d_ready);
    end
    d_wen = 0;
    tick;
    nRST = 1; exp_i = '0; exp_d = '0; last_side = 0;
    i_req = 1; i_addr = 32'h10;
    tick; tests++;
    if ({ram_ren, ram_wen, busy, d_ready, ram_addr} !== {4'b1010, 32'h10}) begin
      fails++; $display("FAIL midrst_regrant: ren/wen/busy/dr=%b%b%b%b addr=%h", ram_ren, ram_wen, busy, d_ready, ram_addr);
    end
    repeat (L - 1) tick;
    tick; tests++;
    if ({i_ready, d_ready, i_rdata} !== {2'b10, 32'h0010_0093}) begin
      fails++; $display("FAIL midrst_fetch: ir/dr=%b%b i_rdata=%h", i_ready, d_ready, i_rdata);
    end
    i_req = 0; exp_i = 32'h0010_0093;
    tick;
  endtask

  task automatic test_random;
    logic i_p, d_p, en, en_prev, ok;
    logic [31:0] ia, da, dw;
    int dop, ig, dg, iw, dwt, run;
    const int bound = 3 * (L + 2);
    init_req = 1; tick; init_req = 0;
    for (int k = 0; k < 64; k++) ref_mem[k] = init_val(k);
    i_p = 0; d_p = 0; en_prev = 0; ig = 0; dg = 1; iw = 0; dwt = 0; run = 0; dop = 0;
    ia = '0; da = '0; dw = '0;
    for (int c = 0; c < 4000; c++) begin
      tick;
      en = ram_ren | ram_wen;
      if (en && !en_prev) begin
        tests++;
        ok = ram_wen ? (d_p && dop != 0 && !ram_ren && ram_addr == da && ram_wdata == dw)
                     : ((i_p && ram_addr == ia) || (d_p && dop == 0 && ram_addr == da));
        if (!ok) begin fails++; $display("FAIL rnd_grant c%0d: ren=%b wen=%b addr=%h no matching request", c, ram_ren, ram_wen, ram_addr); end
      end
      if (en) run++;
      else if (en_prev) begin
        tests++;
        if (run != L) begin fails++; $display("FAIL rnd_access_len c%0d: got %0d cycles want %0d", c, run, L); end
        run = 0;
      end
      en_prev = en;
      if (i_ready) begin
        tests++;
        if (!i_p || i_rdata !== ref_mem[ia[7:2]]) begin
          fails++; $display("FAIL rnd_fetch c%0d: pend=%b i_rdata=%h want %h", c, i_p, i_rdata, ref_mem[ia[7:2]]);
        end
        exp_i = ref_mem[ia[7:2]]; i_p = 0; ig = $urandom_range(0, 3);
      end
      if (d_ready) begin
        tests++;
        if (!d_p) begin fails++; $display("FAIL rnd_dready c%0d: ready with no request", c); end
        if (dop != 0) ref_mem[da[7:2]] = dw; else exp_d = ref_mem[da[7:2]];
        d_p = 0; dg = $urandom_range(0, 3);
      end
      tests++;
      if (i_rdata !== exp_i || d_rdata !== exp_d) begin
        fails++; $display("FAIL rnd_rdata c%0d: i=%h want %h d=%h want %h", c, i_rdata, exp_i, d_rdata, exp_d);
      end
      if (i_p) iw++;
      if (d_p) dwt++;
      if (iw > bound || dwt > bound) begin
        tests++; fails++; $display("FAIL rnd_timeout c%0d: i_wait=%0d d_wait=%0d limit %0d", c, iw, dwt, bound);
        break;
      end
      if (c < 3800) begin
        if (!i_p) begin
          if (ig == 0) begin i_p = 1; iw = 0; ia = {24'h0, 6'($urandom_range(0, 63)), 2'b00}; end
          else ig--;
        end
        if (!d_p) begin
          if (dg == 0) begin
            d_p = 1; dwt = 0; dop = $urandom_range(0, 2); dw = $urandom;
            da = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
          end else dg--;
        end
      end else if (!i_p && !d_p && !en) break;
      i_req = i_p; i_addr = ia;
      d_ren = d_p && dop != 1; d_wen = d_p && dop != 0; d_addr = da; d_wdata = dw;
    end
    i_req = 0; d_ren = 0; d_wen = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_write_read;
    test_both_ops;
    test_priority;
    test_reset_mid_write;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
